// File: rtl/mem_loader.sv
// mem_loader: serial program loader for the development memory.
//
// Parses a framed byte stream {addr_hi, addr_lo, len, payload[len], csum}
// and writes each payload byte straight into RAM (0x0000-0x0FFF) as it
// arrives. The loader owns the memory bus (cpu_hold=1) from the cycle after
// the first header byte until the frame completes, aborts or is reset.
//
// Ports:
//   ph1            clock, all state updates on posedge
//   reset          synchronous active-high reset
//   rx_valid/rx_data/rx_ready  byte-stream handshake (transfer on valid&ready)
//   address        memory bus address (current write pointer)
//   data_out       memory write data (tristated externally by data_oe)
//   data_oe        loader drives the memory data bus
//   read_write_sel 1 = read, 0 = write
//   cpu_hold       loader owns the bus, CPU stalled
//   done           one-cycle pulse after a completed frame's csum byte
//   err_csum/err_range/err_timeout  sticky status, cleared by next frame
module mem_loader #(
  parameter int TIMEOUT = 1000
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [15:0] address,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        read_write_sel,
  output logic        cpu_hold,
  output logic        done,
  output logic        err_csum,
  output logic        err_range,
  output logic        err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ADDR_LO = 3'd1;
  localparam logic [2:0] LEN     = 3'd2;
  localparam logic [2:0] DATA    = 3'd3;
  localparam logic [2:0] WRITE   = 3'd4;
  localparam logic [2:0] CSUM    = 3'd5;

  logic [2:0]    state;
  logic [15:0]   addr;
  logic [7:0]    data_reg;
  logic [8:0]    cnt;        // payload bytes still to write (1..256)
  logic [7:0]    csum_acc;
  logic [TW-1:0] tcnt;       // idle cycles since last accepted byte

  logic accept;
  logic in_ram;
  logic waiting;
  logic timed_out;
  logic wr_en;

  assign in_ram    = (addr[15:12] == 4'h0);
  assign rx_ready  = (state != WRITE);
  assign accept    = rx_valid & rx_ready;
  assign waiting   = (state == ADDR_LO) || (state == LEN) ||
                     (state == DATA)    || (state == CSUM);
  assign timed_out = waiting & ~accept & (tcnt == TW'(TIMEOUT - 1));

  // Reset is folded in combinationally so a write cycle that coincides with
  // reset never reaches the memory, which samples mid-cycle on ph2.
  assign wr_en          = (state == WRITE) & in_ram & ~reset;
  assign read_write_sel = ~wr_en;
  assign data_oe        = wr_en;
  assign address        = addr;
  assign data_out       = data_reg;
  assign cpu_hold       = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge ph1) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= 16'h0000;
      data_reg    <= 8'h00;
      cnt         <= 9'd0;
      csum_acc    <= 8'h00;
      tcnt        <= '0;
      done        <= 1'b0;
      err_csum    <= 1'b0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done <= 1'b0;

      // Idle-cycle counter: restarts on every byte and outside the
      // byte-waiting states, so WRITE can never time out.
      if (accept || !waiting || timed_out) tcnt <= '0;
      else                                 tcnt <= tcnt + 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            addr[15:8]  <= rx_data;
            csum_acc    <= rx_data;
            err_csum    <= 1'b0;
            err_range   <= 1'b0;
            err_timeout <= 1'b0;
            state       <= ADDR_LO;
          end
        end
        ADDR_LO: begin
          if (accept) begin
            addr[7:0] <= rx_data;
            csum_acc  <= csum_acc ^ rx_data;
            state     <= LEN;
          end
        end
        LEN: begin
          if (accept) begin
            // A length byte of zero encodes a full 256-byte payload.
            cnt      <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            csum_acc <= csum_acc ^ rx_data;
            state    <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            data_reg <= rx_data;
            csum_acc <= csum_acc ^ rx_data;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (!in_ram) err_range <= 1'b1;
          addr  <= addr + 16'd1;
          cnt   <= cnt - 9'd1;
          state <= (cnt == 9'd1) ? CSUM : DATA;
        end
        CSUM: begin
          if (accept) begin
            err_csum <= (rx_data != csum_acc);
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Abort overrides the state update above; already-written bytes stay.
      if (timed_out) begin
        err_timeout <= 1'b1;
        state       <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: a frame-level reference model (byte
// position within the frame, bytes left, idle-cycle count) predicts every
// output each cycle; a RAM image captured from the bus is compared with the
// model's expected RAM image at the end.
module tb_mem_loader;

  localparam int TO = 60;

  logic        ph1 = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic [15:0] address;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        read_write_sel;
  logic        cpu_hold;
  logic        done;
  logic        err_csum;
  logic        err_range;
  logic        err_timeout;

  mem_loader #(.TIMEOUT(TO)) dut (
    .ph1            (ph1),
    .reset          (reset),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .address        (address),
    .data_out       (data_out),
    .data_oe        (data_oe),
    .read_write_sel (read_write_sel),
    .cpu_hold       (cpu_hold),
    .done           (done),
    .err_csum       (err_csum),
    .err_range      (err_range),
    .err_timeout    (err_timeout)
  );

  always #5 ph1 = ~ph1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_idx  = 0;      // bytes accepted so far in this frame (0 = idle)
  int          m_left = 0;      // payload bytes not yet written
  int          m_wait = 0;      // consecutive cycles without a byte
  bit          m_busy = 0;      // cycle after a payload byte: write on the bus
  bit          m_done = 0;
  bit          m_ec = 0, m_er = 0, m_et = 0;
  logic [15:0] m_addr = 16'h0000;
  logic [7:0]  m_data = 8'h00;
  logic [7:0]  m_csum = 8'h00;
  logic [7:0]  mem_exp [0:4095] = '{default: 8'h00};

  always @(posedge ph1) begin
    if (m_busy && m_addr < 16'h1000 && !reset) mem_exp[m_addr[11:0]] = m_data;
    if (reset) begin
      m_idx = 0; m_left = 0; m_wait = 0; m_busy = 0; m_done = 0;
      m_ec = 0; m_er = 0; m_et = 0; m_addr = 16'h0000; m_data = 8'h00;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (m_addr >= 16'h1000) m_er = 1;
        m_addr = m_addr + 16'd1;
        m_left--;
        m_busy = 0;
        m_wait = 0;
      end else if (rx_valid) begin
        m_wait = 0;
        if (m_idx == 0) begin
          m_ec = 0; m_er = 0; m_et = 0;
          m_addr[15:8] = rx_data; m_csum = rx_data; m_idx = 1;
        end else if (m_idx == 1) begin
          m_addr[7:0] = rx_data; m_csum ^= rx_data; m_idx = 2;
        end else if (m_idx == 2) begin
          m_left = (rx_data == 8'h00) ? 256 : int'(rx_data);
          m_csum ^= rx_data; m_idx = 3;
        end else if (m_left > 0) begin
          m_data = rx_data; m_csum ^= rx_data; m_busy = 1; m_idx++;
        end else begin
          m_ec = (rx_data != m_csum); m_done = 1; m_idx = 0;
        end
      end else if (m_idx != 0) begin
        m_wait++;
        if (m_wait == TO) begin
          m_et = 1; m_idx = 0; m_wait = 0;
        end
      end
    end
  end

  // ---------------- compare process + bus-side RAM ----------------
  logic [7:0] ram [0:4095] = '{default: 8'h00};
  int n_writes = 0;
  int n_done = 0;

  always @(negedge ph1) begin
    bit exp_wr;
    exp_wr = m_busy && (m_addr < 16'h1000) && !reset;
    check("outputs",
          {rx_ready, cpu_hold, read_write_sel, data_oe, done,
           err_csum, err_range, err_timeout, address, data_out},
          {!m_busy, m_idx != 0, !exp_wr, exp_wr, m_done,
           m_ec, m_er, m_et, m_addr, m_data});
    if (read_write_sel === 1'b0) begin
      ram[address[11:0]] = data_out;
      n_writes++;
    end
    if (done === 1'b1) n_done++;
  end

  // ---------------- stimulus ----------------
  logic [7:0] pay [0:255];

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    repeat (gap) begin
      rx_valid = 1'b0; rx_data = 8'($urandom);
      @(posedge ph1); #1;
    end
    rx_valid = 1'b1; rx_data = b;
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge ph1);
      ok = (rx_ready === 1'b1);
      @(posedge ph1); #1;
    end
    if (!ok) check("accept_bound", 0, 1);
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  function automatic int rgap(input int gapmax);
    return int'($urandom_range(gapmax, 0));
  endfunction

  // Sends a frame with payload pay[]; csum_xor=0 yields the correct checksum.
  task automatic send_frame(input logic [15:0] a, input logic [7:0] lenb,
                            input int gapmax, input logic [7:0] csum_xor);
    int n;
    logic [7:0] cs;
    n  = (lenb == 8'h00) ? 256 : int'(lenb);
    cs = a[15:8] ^ a[7:0] ^ lenb;
    send_byte(a[15:8], rgap(gapmax));
    send_byte(a[7:0], rgap(gapmax));
    send_byte(lenb, rgap(gapmax));
    for (int i = 0; i < n; i++) begin
      cs ^= pay[i];
      send_byte(pay[i], rgap(gapmax));
    end
    send_byte(cs ^ csum_xor, rgap(gapmax));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, mism;
    logic [15:0] a;

    repeat (2) @(posedge ph1);
    #1;
    check("reset_values",
          {rx_ready, cpu_hold, read_write_sel, data_oe, done,
           err_csum, err_range, err_timeout, address, data_out},
          {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 16'h0000, 8'h00});
    reset = 1'b0;
    @(posedge ph1); #1;

    // Frame 00 10 03 AA BB CC, checksum 00^10^03^AA^BB^CC = CE.
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
    w0 = n_writes; d0 = n_done;
    send_frame(16'h0010, 8'h03, 0, 8'h00);
    @(posedge ph1); #1;
    check("f1_ram10", ram[12'h010], 8'hAA);
    check("f1_ram11", ram[12'h011], 8'hBB);
    check("f1_ram12", ram[12'h012], 8'hCC);
    check("f1_writes", n_writes - w0, 3);
    check("f1_done", n_done - d0, 1);
    check("f1_errs", {err_csum, err_range, err_timeout}, 3'b000);

    // 256-byte frame (len byte 0) at 0x0F00.
    for (int i = 0; i < 256; i++) pay[i] = 8'(i);
    w0 = n_writes; d0 = n_done;
    send_frame(16'h0F00, 8'h00, 0, 8'h00);
    @(posedge ph1); #1;
    check("f256_ram_first", ram[12'hF00], 8'h00);
    check("f256_ram_mid", ram[12'hF7F], 8'h7F);
    check("f256_ram_last", ram[12'hFFF], 8'hFF);
    check("f256_writes", n_writes - w0, 256);
    check("f256_done", n_done - d0, 1);
    check("f256_err_range", err_range, 1'b0);

    // Frame crossing the top of RAM: second byte at 0x1000 is dropped.
    pay[0] = 8'h11; pay[1] = 8'h22;
    w0 = n_writes;
    send_frame(16'h0FFF, 8'h02, 1, 8'h00);
    @(posedge ph1); #1;
    check("range_ram_fff", ram[12'hFFF], 8'h11);
    check("range_writes", n_writes - w0, 1);
    check("range_err_range", err_range, 1'b1);
    check("range_err_csum", err_csum, 1'b0);

    // First frame again with csum 00 (correct would be CE).
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
    d0 = n_done;
    send_frame(16'h0010, 8'h03, 0, 8'hCE);
    @(posedge ph1); #1;
    check("badcs_done", n_done - d0, 1);
    check("badcs_err_csum", err_csum, 1'b1);
    check("badcs_ram12", ram[12'h012], 8'hCC);

    // Next frame: first byte clears err_csum; then stall after LEN.
    d0 = n_done;
    send_byte(8'h00, 0);
    check("next_clears_err_csum", err_csum, 1'b0);
    send_byte(8'h20, 0);
    send_byte(8'h02, 0);
    repeat (TO + 2) @(posedge ph1);
    #1;
    check("timeout_err", err_timeout, 1'b1);
    check("timeout_hold", cpu_hold, 1'b0);
    check("timeout_no_done", n_done - d0, 0);
    pay[0] = 8'h77;
    send_frame(16'h0030, 8'h01, 0, 8'h00);
    @(posedge ph1); #1;
    check("after_timeout_ram30", ram[12'h030], 8'h77);
    check("after_timeout_err", err_timeout, 1'b0);

    // Reset asserted during the WRITE cycle of the only payload byte.
    w0 = n_writes;
    send_byte(8'h00, 0);
    send_byte(8'h40, 0);
    send_byte(8'h01, 0);
    send_byte(8'h99, 0);
    reset = 1'b1;
    @(posedge ph1); #1;
    reset = 1'b0;
    check("rst_write_suppressed", n_writes - w0, 0);
    check("rst_ram40", ram[12'h040], 8'h00);
    check("rst_outputs",
          {rx_ready, cpu_hold, read_write_sel, data_oe, done, address, data_out},
          {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00});

    // Randomised frames: in-range, near the RAM top, wrapping, out of range.
    for (int f = 0; f < 40; f++) begin
      int n;
      case ($urandom_range(3, 0))
        0:       a = 16'($urandom_range(16'h0FFF, 0));
        1:       a = 16'h0FFC + 16'($urandom_range(3, 0));
        2:       a = 16'hFFFE;
        default: a = 16'($urandom);
      endcase
      n = int'($urandom_range(6, 1));
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      send_frame(a, 8'(n), 3, ($urandom_range(4, 0) == 0) ? 8'h5A : 8'h00);
    end
    repeat (3) @(posedge ph1);
    #1;

    mism = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== mem_exp[i]) mism++;
    check("ram_image", mism, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
